// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared size encodings, FSM state type and access-legality check
//            for the load/store unit.
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WSETUP = 3'd2,
        ST_WPULSE = 3'd3,
        ST_WHOLD  = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_t;

    // Illegal size or an address not aligned to the access size.
    function automatic logic access_error(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: access_error = 1'b0;
            SZ_HALF: access_error = addr_lo[0];
            SZ_WORD: access_error = |addr_lo;
            default: access_error = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational little-endian lane extraction with sign/zero
//            extension for loads, and lane merge for sub-word stores.
// Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_size)
            SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    // Unaddressed lanes keep the word just fetched from memory.
    always_comb begin
        o_merged = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr_lo)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
                else              o_merged[15:0]  = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Data-memory initiator for byte/half/word loads and stores, with
//            read-modify-write for sub-word stores. Optional performance
//            counters are enabled by defining LSU_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 16
)(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqUnsigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RspValid,
    output logic [31:0] RspData,
    output logic        RspError,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] ReadData
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] LoadCount,
    output logic [CNT_W-1:0] StoreCount,
    output logic [CNT_W-1:0] ErrCount
`endif
);

    if (WAIT_CYCLES < 1) begin : g_wait_check
        $error("load_store_unit: WAIT_CYCLES must be at least 1");
    end
    if (CNT_W < 1) begin : g_cnt_check
        $error("load_store_unit: CNT_W must be at least 1");
    end

    localparam int                c_WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_CYCLES - 1);

    lsu_state_t          r_state;
    lsu_state_t          w_next_state;
    logic                r_write;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic                r_err;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rsp_data;
    logic [c_WAIT_W-1:0] r_wait;

    logic                w_req_err;
    logic                w_read_last;
    logic                w_wr_phase;
    logic                w_mem_phase;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merged;

    assign w_req_err   = access_error(ReqSize, ReqAddr[1:0]);
    assign w_read_last = (r_wait == c_WAIT_LAST);

    always_ff @(posedge Clock) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ReqValid) begin
                    if (w_req_err)                         w_next_state = ST_RESP;
                    else if (ReqWrite && ReqSize == SZ_WORD) w_next_state = ST_WSETUP;
                    else                                   w_next_state = ST_READ;
                end
            end
            ST_READ:   if (w_read_last) w_next_state = r_write ? ST_WSETUP : ST_RESP;
            ST_WSETUP: w_next_state = ST_WPULSE;
            ST_WPULSE: w_next_state = ST_WHOLD;
            ST_WHOLD:  w_next_state = ST_RESP;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Request fields are captured on acceptance; the merged store word or the
    // extended load result is captured on the last READ edge.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_wait     <= '0;
        end else if (r_state == ST_IDLE && ReqValid) begin
            r_write    <= ReqWrite;
            r_size     <= ReqSize;
            r_unsigned <= ReqUnsigned;
            r_err      <= w_req_err;
            r_addr     <= ReqAddr;
            r_wdata    <= ReqWData;
            r_rsp_data <= '0;
            r_wait     <= '0;
        end else if (r_state == ST_READ) begin
            r_wait <= r_wait + 1'b1;
            if (w_read_last) begin
                if (r_write) r_wdata    <= w_merged;
                else         r_rsp_data <= w_load_data;
            end
        end
    end

    lsu_lane_align u_align (
        .i_addr_lo   (r_addr[1:0]),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_rdata     (ReadData),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    assign w_wr_phase  = (r_state == ST_WSETUP) || (r_state == ST_WPULSE) ||
                         (r_state == ST_WHOLD);
    assign w_mem_phase = w_wr_phase || (r_state == ST_READ);

    assign ReqReady  = (r_state == ST_IDLE);
    assign RspValid  = (r_state == ST_RESP);
    assign RspData   = (r_state == ST_RESP) ? r_rsp_data : '0;
    assign RspError  = (r_state == ST_RESP) && r_err;
    assign MemRead   = (r_state == ST_READ);
    assign MemWrite  = (r_state == ST_WPULSE);
    assign Address   = w_mem_phase ? {2'b00, r_addr[31:2]} : '0;
    assign WriteData = w_wr_phase ? r_wdata : '0;

`ifdef LSU_PERF_CNT_EN
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_store_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // Saturating counters, one bump per response of the matching class.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (r_state == ST_RESP) begin
            if (r_err) begin
                if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
            end else if (r_write) begin
                if (!(&r_store_cnt)) r_store_cnt <= r_store_cnt + 1'b1;
            end else begin
                if (!(&r_load_cnt)) r_load_cnt <= r_load_cnt + 1'b1;
            end
        end
    end

    assign LoadCount  = r_load_cnt;
    assign StoreCount = r_store_cnt;
    assign ErrCount   = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard bench driving two load_store_unit instances
//            (WAIT_CYCLES 1 and 3) with identical directed requests.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at_cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        ready      [2];
    logic        rsp_valid  [2];
    logic        rsp_error  [2];
    logic        mem_write  [2];
    logic        mem_read   [2];
    logic [31:0] rsp_data   [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] mem        [2][64];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          accept_cyc = 0;
    exp_t        sb0 [$];
    exp_t        sb1 [$];

    int          wr_cnt   [2];
    int          rd_cnt   [2];
    int          both_cnt [2];
    int          wr_cyc   [2];
    logic [31:0] wr_addr  [2];
    logic [31:0] wr_data  [2];
    logic        mw_prev  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        wire [31:0] w_rdata;
        assign w_rdata = mem_read[gi] ? mem[gi][address[gi][5:0]] : 32'hz;
`ifdef LSU_PERF_CNT_EN
        wire [15:0] w_lc;
        wire [15:0] w_sc;
        wire [15:0] w_ec;
`endif
        load_store_unit #(
            .WAIT_CYCLES ((gi == 0) ? 1 : 3),
            .CNT_W       (16)
        ) u_dut (
            .Clock       (clk),
            .Reset_n     (rst_n),
            .ReqValid    (req_valid),
            .ReqReady    (ready[gi]),
            .ReqWrite    (req_write),
            .ReqSize     (req_size),
            .ReqUnsigned (req_unsigned),
            .ReqAddr     (req_addr),
            .ReqWData    (req_wdata),
            .RspValid    (rsp_valid[gi]),
            .RspData     (rsp_data[gi]),
            .RspError    (rsp_error[gi]),
            .Address     (address[gi]),
            .WriteData   (write_data[gi]),
            .MemWrite    (mem_write[gi]),
            .MemRead     (mem_read[gi]),
            .ReadData    (w_rdata)
`ifdef LSU_PERF_CNT_EN
            ,
            .LoadCount   (w_lc),
            .StoreCount  (w_sc),
            .ErrCount    (w_ec)
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int w, input logic err, input logic wr, input logic [1:0] sz);
        if (err) return 1;
        if (!wr) return w + 1;
        if (sz == 2'b10) return 4;
        return w + 4;
    endfunction

    // Memory model plus response monitor; memory updates on MemWrite rising.
    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 64; k++) mem[i][k] = 32'h0;
            mem[i][4]   = 32'h8899AABB;
            wr_cnt[i]   = 0;
            rd_cnt[i]   = 0;
            both_cnt[i] = 0;
            wr_cyc[i]   = 0;
            wr_addr[i]  = 32'h0;
            wr_data[i]  = 32'h0;
            mw_prev[i]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                bit   got;
                if (mem_write[i] && !mw_prev[i]) begin
                    mem[i][address[i][5:0]] = write_data[i];
                    wr_cnt[i]++;
                    wr_cyc[i]  = cyc;
                    wr_addr[i] = address[i];
                    wr_data[i] = write_data[i];
                end
                mw_prev[i] = mem_write[i];
                if (mem_read[i]) rd_cnt[i]++;
                if (mem_read[i] && mem_write[i]) both_cnt[i]++;
                if (rsp_valid[i]) begin
                    got = 1'b0;
                    if (i == 0 && sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
                    if (i == 1 && sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
                    if (!got) begin
                        check($sformatf("w%0d_unexpected_rsp", wait_of(i)), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("w%0d_%s_data", wait_of(i), e.name), rsp_data[i], e.data);
                        check($sformatf("w%0d_%s_err", wait_of(i), e.name), {31'd0, rsp_error[i]}, {31'd0, e.err});
                        check($sformatf("w%0d_%s_cycle", wait_of(i), e.name), cyc, e.at_cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err, input bit push);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!(ready[0] && ready[1]) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_ready_wait"}, {31'd0, ready[0] && ready[1]}, 32'd1);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        accept_cyc = cyc;
        if (push) begin
            e.data = exp_data;
            e.err  = exp_err;
            e.name = name;
            e.at_cyc = accept_cyc + exp_lat(1, exp_err, wr, sz) - 1;
            sb0.push_back(e);
            e.at_cyc = accept_cyc + exp_lat(3, exp_err, wr, sz) - 1;
            sb1.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_pending_rsp"}, sb0.size() + sb1.size(), 32'd0);
        sb0.delete();
        sb1.delete();
        @(posedge clk);
    endtask

    task automatic run(input string name, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err,
                       input int exp_writes, input int exp_word_idx, input logic [31:0] exp_word);
        int wb [2];
        int rb [2];
        for (int i = 0; i < 2; i++) begin wb[i] = wr_cnt[i]; rb[i] = rd_cnt[i]; end
        issue(name, wr, sz, uns, addr, wdata, exp_data, exp_err, 1'b1);
        wait_done(name);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("w%0d_%s_write_pulses", wait_of(i), name), wr_cnt[i] - wb[i], exp_writes);
            if (exp_err) check($sformatf("w%0d_%s_no_read", wait_of(i), name), rd_cnt[i] - rb[i], 32'd0);
            if (exp_writes > 0) begin
                check($sformatf("w%0d_%s_wr_addr", wait_of(i), name), wr_addr[i], exp_word_idx);
                check($sformatf("w%0d_%s_wr_data", wait_of(i), name), wr_data[i], exp_word);
                check($sformatf("w%0d_%s_mem", wait_of(i), name), mem[i][exp_word_idx], exp_word);
                if (sz == 2'b10)
                    check($sformatf("w%0d_%s_wr_cycle", wait_of(i), name), wr_cyc[i] - accept_cyc + 1, 32'd2);
            end
        end
    endtask

    initial begin
        int wb [2];
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("w%0d_rst_ready", wait_of(i)), {31'd0, ready[i]}, 32'd1);
            check($sformatf("w%0d_rst_rspvalid", wait_of(i)), {31'd0, rsp_valid[i]}, 32'd0);
            check($sformatf("w%0d_rst_memrw", wait_of(i)), {30'd0, mem_read[i], mem_write[i]}, 32'd0);
            check($sformatf("w%0d_rst_address", wait_of(i)), address[i], 32'd0);
            check($sformatf("w%0d_rst_wdata", wait_of(i)), write_data[i], 32'd0);
            check($sformatf("w%0d_rst_rspdata", wait_of(i)), rsp_data[i] | {31'd0, rsp_error[i]}, 32'd0);
        end
        rst_n = 1'b1;

        //   name           wr    size   uns   addr      wdata          data           err writes idx  word
        run("lb_11",        1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 0, 0, 32'h0);
        run("lhu_12",       1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00008899, 1'b0, 0, 0, 32'h0);
        run("lh_10",        1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 0, 0, 32'h0);
        run("sb_13",        1'b1, 2'b00, 1'b0, 32'h13, 32'h000000CC, 32'h0,        1'b0, 1, 4, 32'hCC99AABB);
        run("lw_10",        1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hCC99AABB, 1'b0, 0, 0, 32'h0);
        run("lw_12_misal",  1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 0, 0, 32'h0);
        run("size11",       1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 0, 0, 32'h0);
        run("sh_11_misal",  1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF, 32'h0,        1'b1, 0, 0, 32'h0);
        run("sh_12",        1'b1, 2'b01, 1'b0, 32'h12, 32'h5555DEAD, 32'h0,        1'b0, 1, 4, 32'hDEADAABB);
        run("sw_20",        1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0,        1'b0, 1, 8, 32'h12345678);
        run("lbu_23",       1'b0, 2'b00, 1'b1, 32'h23, 32'h0,        32'h00000012, 1'b0, 0, 0, 32'h0);
        run("lb_13",        1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 0, 0, 32'h0);

        // Word store aborted by reset while in WSETUP.
        for (int i = 0; i < 2; i++) wb[i] = wr_cnt[i];
        issue("sw_rst", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("w%0d_rst_mid_ready", wait_of(i)), {31'd0, ready[i]}, 32'd1);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("w%0d_rst_mid_no_write", wait_of(i)), wr_cnt[i] - wb[i], 32'd0);
            check($sformatf("w%0d_rst_mid_mem", wait_of(i)), mem[i][8], 32'h12345678);
        end

        run("lw_20_after", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 0, 0, 32'h0);

        for (int i = 0; i < 2; i++)
            check($sformatf("w%0d_rd_wr_overlap", wait_of(i)), both_cnt[i], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
